// File: rtl/pipelined_mux_tree.sv
// Pipelined N:1 channel selector built from registered 4:1 stages (the final
// stage is 2:1 when SEL_W is odd). The select comes either from sel_in or
// from an internal scan counter that sweeps every channel in order. hold
// freezes the whole pipeline and the counter. data_out/sel_out keep the last
// valid result while out_valid is low.
module pipelined_mux_tree #(
  parameter  int DATA_W = 1,
  parameter  int SEL_W  = 4,
  localparam int N      = 1 << SEL_W,
  localparam int LEVELS = (SEL_W + 1) / 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N*DATA_W-1:0]   data_in,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  in_valid,
  input  logic                  scan_en,
  input  logic                  hold,
  output logic [DATA_W-1:0]     data_out,
  output logic [SEL_W-1:0]      sel_out,
  output logic                  out_valid,
  output logic                  scan_done
);

  logic [SEL_W-1:0] scan_cnt_d, scan_cnt_q;
  logic [SEL_W-1:0] eff_sel;
  logic             eff_vld;
  logic             eff_last;

  // Choose the select/valid source feeding the first stage.
  always_comb begin
    eff_sel  = sel_in;
    eff_vld  = in_valid;
    eff_last = 1'b0;
    if (scan_en) begin
      eff_sel  = scan_cnt_q;
      eff_vld  = 1'b1;
      eff_last = (scan_cnt_q == '1);
    end
  end

  // Scan counter: advance while scanning, park at channel 0 otherwise.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    if (!hold) begin
      scan_cnt_d = scan_en ? (scan_cnt_q + SEL_W'(1)) : '0;
    end
  end

  // Scan counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_stage
    // HALF marks the trailing 2:1 stage that resolves the select MSB.
    localparam bit HALF  = (2*l + 1 == SEL_W);
    localparam bit LAST  = (l == LEVELS - 1);
    localparam int RADIX = HALF ? 2 : 4;
    localparam int CI    = 1 << (SEL_W - 2*l);
    localparam int CO    = CI / RADIX;

    logic [CI*DATA_W-1:0] src_data;
    logic [SEL_W-1:0]     src_sel;
    logic                 src_vld;
    logic                 src_last;
    logic [1:0]           digit;
    logic [CO*DATA_W-1:0] mux;

    // The full select index travels with the data; the bits above the ones
    // consumed here are the remaining select for the stages downstream.
    logic [CO*DATA_W-1:0] data_d, data_q;
    logic [SEL_W-1:0]     sel_d,  sel_q;
    logic                 vld_d,  vld_q;
    logic                 last_d, last_q;

    if (l == 0) begin : g_src
      assign src_data = data_in;
      assign src_sel  = eff_sel;
      assign src_vld  = eff_vld;
      assign src_last = eff_last;
    end else begin : g_src
      assign src_data = g_stage[l-1].data_q;
      assign src_sel  = g_stage[l-1].sel_q;
      assign src_vld  = g_stage[l-1].vld_q;
      assign src_last = g_stage[l-1].last_q;
    end

    if (HALF) begin : g_digit
      assign digit = {1'b0, src_sel[2*l]};
    end else begin : g_digit
      assign digit = src_sel[2*l+1 -: 2];
    end

    // Select one channel out of each group of RADIX inputs.
    always_comb begin
      mux = '0;
      for (int j = 0; j < CO; j++) begin
        mux[j*DATA_W +: DATA_W] = src_data[(j*RADIX + int'(digit))*DATA_W +: DATA_W];
      end
    end

    // Next stage contents; the output stage keeps its last valid result.
    always_comb begin
      data_d = mux;
      sel_d  = src_sel;
      vld_d  = src_vld;
      last_d = src_last;
      if (LAST && !src_vld) begin
        data_d = data_q;
        sel_d  = sel_q;
      end
      if (hold) begin
        data_d = data_q;
        sel_d  = sel_q;
        vld_d  = vld_q;
        last_d = last_q;
      end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        sel_q  <= '0;
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end else begin
        data_q <= data_d;
        sel_q  <= sel_d;
        vld_q  <= vld_d;
        last_q <= last_d;
      end
    end
  end

  assign data_out  = g_stage[LEVELS-1].data_q;
  assign sel_out   = g_stage[LEVELS-1].sel_q;
  assign out_valid = g_stage[LEVELS-1].vld_q;
  assign scan_done = g_stage[LEVELS-1].last_q & g_stage[LEVELS-1].vld_q;

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Bench for pipelined_mux_tree: directed scenarios plus random traffic on the
// default configuration, compared against a transaction-level delay-line
// model, and scan sweeps on three DATA_W=8 configurations.
module tb_pipelined_mux_tree;

  localparam int L   = 2;
  localparam int NCH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  sel_in;
  logic        in_valid;
  logic        scan_en;
  logic        hold;
  logic        data_out;
  logic [3:0]  sel_out;
  logic        out_valid;
  logic        scan_done;

  logic        scan_en_p;
  logic [15:0]  din_p1;
  logic [63:0]  din_p3;
  logic [255:0] din_p5;
  logic [7:0]  dout_p1, dout_p3, dout_p5;
  logic [0:0]  sout_p1;
  logic [2:0]  sout_p3;
  logic [4:0]  sout_p5;
  logic        ov_p1, ov_p3, ov_p5;
  logic        sd_p1, sd_p3, sd_p5;

  always #5 clk = ~clk;

  pipelined_mux_tree #(.DATA_W(1), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel_in(sel_in),
    .in_valid(in_valid), .scan_en(scan_en), .hold(hold),
    .data_out(data_out), .sel_out(sel_out), .out_valid(out_valid),
    .scan_done(scan_done));

  pipelined_mux_tree #(.DATA_W(8), .SEL_W(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n), .data_in(din_p1), .sel_in('0),
    .in_valid(1'b0), .scan_en(scan_en_p), .hold(1'b0),
    .data_out(dout_p1), .sel_out(sout_p1), .out_valid(ov_p1),
    .scan_done(sd_p1));

  pipelined_mux_tree #(.DATA_W(8), .SEL_W(3)) dut_p3 (
    .clk(clk), .rst_n(rst_n), .data_in(din_p3), .sel_in('0),
    .in_valid(1'b0), .scan_en(scan_en_p), .hold(1'b0),
    .data_out(dout_p3), .sel_out(sout_p3), .out_valid(ov_p3),
    .scan_done(sd_p3));

  pipelined_mux_tree #(.DATA_W(8), .SEL_W(5)) dut_p5 (
    .clk(clk), .rst_n(rst_n), .data_in(din_p5), .sel_in('0),
    .in_valid(1'b0), .scan_en(scan_en_p), .hold(1'b0),
    .data_out(dout_p5), .sel_out(sout_p5), .out_valid(ov_p5),
    .scan_done(sd_p5));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: each accepted transaction is a {valid, sel, data, last}
  // record resolved at sample time, delayed through L slots.
  int         m_cnt;
  logic       mp_v [L];
  logic       mp_l [L];
  logic       mp_d [L];
  logic [3:0] mp_s [L];
  logic       m_dout;
  logic [3:0] m_sout;

  task automatic model_reset();
    m_cnt  = 0;
    m_dout = 1'b0;
    m_sout = 4'd0;
    for (int i = 0; i < L; i++) begin
      mp_v[i] = 1'b0; mp_l[i] = 1'b0; mp_d[i] = 1'b0; mp_s[i] = 4'd0;
    end
  endtask

  task automatic model_edge();
    logic       nv, nl, nd;
    logic [3:0] ns;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (hold) return;
    if (scan_en) begin
      ns = 4'(m_cnt); nv = 1'b1; nl = (m_cnt == NCH - 1);
    end else begin
      ns = sel_in; nv = in_valid; nl = 1'b0;
    end
    nd = data_in[ns];
    for (int i = L - 1; i > 0; i--) begin
      mp_v[i] = mp_v[i-1]; mp_l[i] = mp_l[i-1]; mp_d[i] = mp_d[i-1]; mp_s[i] = mp_s[i-1];
    end
    mp_v[0] = nv; mp_l[0] = nl; mp_d[0] = nd; mp_s[0] = ns;
    if (mp_v[L-1]) begin
      m_dout = mp_d[L-1];
      m_sout = mp_s[L-1];
    end
    m_cnt = scan_en ? (m_cnt + 1) % NCH : 0;
  endtask

  task automatic compare();
    check("data_out",  data_out,  m_dout);
    check("sel_out",   sel_out,   m_sout);
    check("out_valid", out_valid, mp_v[L-1]);
    check("scan_done", scan_done, mp_v[L-1] & mp_l[L-1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Reset pulse placed between clock edges.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    check("rst.p5_valid", ov_p5, 1'b0);
    check("rst.p5_sel", sout_p5, 5'd0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_p(input string tag, input int lv, input int n, input int k,
                         input logic ov, input logic [7:0] dout, input int sout, input logic sd);
    int es;
    check({tag, ".out_valid"}, ov, (k >= lv) ? 1 : 0);
    if (k >= lv) begin
      es = (k - lv) % n;
      check({tag, ".sel_out"}, sout, es);
      check({tag, ".data_out"}, dout, es);
      check({tag, ".scan_done"}, sd, (es == n - 1) ? 1 : 0);
    end
  endtask

  bit exp30 [16] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    logic [3:0] s_before;
    rst_n = 1'b0; data_in = '0; sel_in = '0; in_valid = 1'b0;
    scan_en = 1'b0; hold = 1'b0; scan_en_p = 1'b0;
    for (int k = 0; k < 2;  k++) din_p1[k*8 +: 8] = 8'(k);
    for (int k = 0; k < 8;  k++) din_p3[k*8 +: 8] = 8'(k);
    for (int k = 0; k < 32; k++) din_p5[k*8 +: 8] = 8'(k);
    model_reset();
    #1;
    compare();
    repeat (2) step();
    rst_n = 1'b1;

    // Full scan sweep over a fixed pattern.
    data_in = 16'b1101001110100111;
    scan_en = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      if (k == 17) scan_en = 1'b0;
      step();
      if (k >= 2 && k <= 17) begin
        check("sweep.sel", sel_out, k - 2);
        check("sweep.data", data_out, exp30[k-2]);
        check("sweep.done", scan_done, (k == 17) ? 1 : 0);
      end
    end

    // External select mode.
    sel_in = 4'd9; in_valid = 1'b1;
    step();
    sel_in = 4'd4;
    step();
    check("ext.data9", data_out, 1'b1);
    check("ext.sel9", sel_out, 4'd9);
    in_valid = 1'b0;
    step();
    check("ext.data4", data_out, 1'b0);
    check("ext.sel4", sel_out, 4'd4);
    step();
    check("ext.novalid", out_valid, 1'b0);
    check("ext.hold_sel", sel_out, 4'd4);

    // Hold at scan_cnt = 6.
    scan_en = 1'b1;
    repeat (6) step();
    s_before = sel_out;
    check("hold.pre_sel", s_before, 4'd4);
    hold = 1'b1;
    repeat (3) begin
      step();
      check("hold.sel", sel_out, s_before);
      check("hold.valid", out_valid, 1'b1);
    end
    hold = 1'b0;
    step();
    check("hold.resume5", sel_out, 4'd5);
    step();
    check("hold.resume6", sel_out, 4'd6);
    repeat (12) step();

    // Abort at scan_cnt = 10, then restart.
    scan_en = 1'b0;
    step();
    scan_en = 1'b1;
    repeat (10) step();
    check("abort.sel8", sel_out, 4'd8);
    scan_en = 1'b0;
    step();
    check("abort.sel9", sel_out, 4'd9);
    check("abort.valid9", out_valid, 1'b1);
    step();
    check("abort.drained", out_valid, 1'b0);
    check("abort.no_done", scan_done, 1'b0);
    scan_en = 1'b1;
    repeat (2) step();
    check("restart.sel0", sel_out, 4'd0);
    check("restart.valid", out_valid, 1'b1);

    // Reset in the middle of a sweep.
    repeat (5) step();
    async_reset();
    step();
    check("rst.first_edge", out_valid, 1'b0);
    step();
    check("rst.latency", out_valid, 1'b1);
    check("rst.sel0", sel_out, 4'd0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) scan_en = ~scan_en;
      hold     = ($urandom_range(0, 6) == 0);
      in_valid = 1'($urandom);
      sel_in   = 4'($urandom);
      data_in  = 16'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset();
      step();
    end

    // Parameter sweep: each channel carries its own index.
    scan_en = 1'b0; hold = 1'b0; in_valid = 1'b0;
    repeat (2) step();
    scan_en_p = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_p("p1", 1, 2,  k, ov_p1, dout_p1, int'(sout_p1), sd_p1);
      check_p("p3", 2, 8,  k, ov_p3, dout_p3, int'(sout_p3), sd_p3);
      check_p("p5", 3, 32, k, ov_p5, dout_p5, int'(sout_p5), sd_p5);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipelined_mux_tree.md
PIPELINED_MUX_TREE -- requirements
Module: pipelined_mux_tree

Interface
REQ-001 The module SHALL have parameter DATA_W, default 1, meaning the bit width of each data input channel.
REQ-002 The module SHALL have parameter SEL_W, default 4, meaning the select width; channel count N = 2**SEL_W, legal range 1..8.
REQ-003 The module SHALL define derived constant LEVELS = ceil(SEL_W/2), meaning the number of registered mux stages; default 2.
REQ-004 clk  input  1  meaning the single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  meaning the reset; reset SHALL be asynchronous and active-low.
REQ-006 data_in  input  N*DATA_W  meaning the channel inputs; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 sel_in  input  SEL_W  meaning the external channel select, used when scan_en=0.
REQ-008 in_valid  input  1  meaning sel_in/data_in are to be sampled this cycle (external mode only).
REQ-009 scan_en  input  1  meaning auto-scan mode, in which an internal counter supplies the select.
REQ-010 hold  input  1  meaning a stall that freezes the whole pipeline and the scan counter.
REQ-011 data_out  output  DATA_W  meaning the selected channel data.
REQ-012 sel_out  output  SEL_W  meaning the select index that produced data_out.
REQ-013 out_valid  output  1  meaning data_out/sel_out hold a valid result.
REQ-014 scan_done  output  1  meaning a one-cycle pulse marking the last channel of a scan sweep.

Function
REQ-015 The tree SHALL be built from 4:1 stages, selecting on sel bits [1:0] at stage 1, [3:2] at stage 2, and so on; when SEL_W is odd, the final stage SHALL be 2:1 on the MSB.
REQ-016 Each stage SHALL register its data, its remaining select bits, its full select index, its valid flag and its last-of-sweep flag.
REQ-017 Latency SHALL be LEVELS edges: inputs sampled on edge E SHALL appear on outputs after edge E+LEVELS-1. The default latency is 2 cycles.
REQ-018 When scan_en=0, the effective select SHALL be sel_in, the effective valid SHALL be in_valid, and the last-of-sweep flag SHALL be 0.
REQ-019 When scan_en=1, the effective select SHALL be scan_cnt, the effective valid SHALL be 1, and in_valid and sel_in SHALL be ignored.
REQ-020 In scan mode, scan_cnt SHALL increment by 1 on every edge with hold=0 and wrap from N-1 to 0.
REQ-021 The last-of-sweep flag SHALL be set when scan_cnt=N-1.
REQ-022 scan_done SHALL equal the registered last-of-sweep flag of the output stage ANDed with out_valid.
REQ-023 When scan_en=0, scan_cnt SHALL be forced to 0 on the next edge, so every sweep starts at channel 0.
REQ-024 A scan_en 1->0 transition mid-sweep SHALL let in-flight entries drain normally.
REQ-025 When hold=1, all stage registers, outputs and scan_cnt SHALL keep their values. Hold SHALL dominate scan_en changes and in_valid.
REQ-026 When an entry has valid=0, it SHALL still propagate. data_out and sel_out SHALL keep their last valid values, and out_valid SHALL be 0.
REQ-027 When SEL_W=1, the block SHALL be a single registered 2:1 stage with LEVELS=1.

Reset
REQ-028 While rst_n=0, all stage registers, scan_cnt, data_out, sel_out, out_valid and scan_done SHALL be 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight entries. The first valid output after release SHALL come from inputs sampled on or after the first post-release edge.

Verification
REQ-030 Scan sweep: defaults, data_in=16'b1101001110100111, scan_en=1 for 16 cycles -> data_out sequence for sel 0..15 = 1,1,1,0,0,1,0,1,1,1,0,0,1,0,1,1; sel_out = 0..15; scan_done high only with sel_out=15.
REQ-031 External mode: in_valid=1 with sel_in=9, then sel_in=4 -> two edges later data_out=1 and sel_out=9, next cycle data_out=0 and sel_out=4; in_valid=0 gives out_valid=0 and holds the prior data.
REQ-032 Hold: assert hold for 3 cycles mid-sweep at scan_cnt=6 -> outputs, out_valid and scan_cnt frozen; the sweep resumes at 6 with no skipped or duplicated index.
REQ-033 Scan abort and restart: scan_en dropped at scan_cnt=10, then reasserted -> in-flight entries 8 and 9 drain; no scan_done; the new sweep starts at sel_out=0.
REQ-034 Reset mid-sweep: rst_n pulsed low between edges -> all outputs 0 immediately; the first post-release valid output follows the REQ-017 latency.
REQ-035 Parameter sweep: DATA_W=8 with SEL_W=1, 3 and 5 (LEVELS=1, 2, 3), each channel holding its own index -> data_out==sel_out for every scanned channel, at latency LEVELS.
